// File: rtl/lab4_g29_pkg.sv
// Shared definitions for the lab4_g29 mux arbiter: sizes, FSM state encoding,
// and the round-robin pick / one-hot helpers.
package lab4_g29_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 4;

    // FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t StIdle  = 1'b0;
    localparam state_t StGrant = 1'b1;

    // First requester with req set, scanning ptr, ptr+1, ... modulo NUM_REQ.
    // Callers only use the result when at least one req bit is set.
    function automatic logic [1:0] rr_pick(input logic [0:NUM_REQ-1] req,
                                           input logic [1:0]         ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // One-hot vector with bit idx set (bit 0 = requester 0 = leftmost).
    function automatic logic [0:NUM_REQ-1] onehot(input logic [1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/lab4_g29_mux_arb_mux4.sv
// The group's 4-bit 4:1 mux. sel_i[0] picks within a pair (a/b, c/d),
// sel_i[1] picks the pair.
module lab4_g29_mux_arb_mux4
    import lab4_g29_pkg::*;
(
    input  logic [0:DATA_W-1] a_i,
    input  logic [0:DATA_W-1] b_i,
    input  logic [0:DATA_W-1] c_i,
    input  logic [0:DATA_W-1] d_i,
    input  logic [0:1]        sel_i,
    output logic [0:DATA_W-1] y_o
);

    // Data select; index = 2*sel_i[1] + sel_i[0]
    always_comb begin
        y_o = a_i;
        case ({sel_i[1], sel_i[0]})
            2'd0:    y_o = a_i;
            2'd1:    y_o = b_i;
            2'd2:    y_o = c_i;
            2'd3:    y_o = d_i;
            default: y_o = a_i;
        endcase
    end

endmodule

// File: rtl/lab4_g29_mux_arb.sv
// Round-robin arbiter/sequencer sharing the 4:1 mux among four requesters.
// Grants one requester for up to MAX_BURST accepted beats, then releases
// through one IDLE cycle. Optional feature macro: LAB4_G29_LOCK_EN adds a
// `lock` input that suspends the burst limit while the owner holds it.
module lab4_g29_mux_arb
    import lab4_g29_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:DATA_W-1] a,
    input  logic [0:DATA_W-1] b,
    input  logic [0:DATA_W-1] c,
    input  logic [0:DATA_W-1] d,
    input  logic [0:NUM_REQ-1] req,
`ifdef LAB4_G29_LOCK_EN
    input  logic              lock,
`endif
    output logic [0:NUM_REQ-1] gnt,
    output logic [0:1]        sel,
    output logic [0:DATA_W-1] y,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              busy
);

    state_t             state_q, state_d;
    logic [0:NUM_REQ-1] gnt_q, gnt_d;
    logic [0:1]         sel_q, sel_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [1:0]         ptr_q, ptr_d;

    logic [1:0] owner;
    logic [1:0] pick;
    logic       owner_req;
    logic       accept;
    logic       at_limit;
    logic       lock_eff;
    logic [4:0] cnt_inc;

`ifdef LAB4_G29_LOCK_EN
    assign lock_eff = lock;
`else
    assign lock_eff = 1'b0;
`endif

    // Owner decode from the registered select and handshake terms
    always_comb begin
        owner     = {sel_q[1], sel_q[0]};
        owner_req = req[owner];
        y_valid   = (state_q == StGrant) && owner_req;
        accept    = y_valid && y_ready;
        cnt_inc   = {1'b0, cnt_q} + 5'd1;
        at_limit  = (cnt_inc >= 5'(MAX_BURST));
        pick      = rr_pick(req, ptr_q);
    end

    // Arbiter FSM, beat counter and round-robin pointer next state
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d   = onehot(pick);
                    sel_d   = {pick[0], pick[1]};
                    cnt_d   = 4'd0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                // sel is left alone on release so y keeps showing the last owner
                if (!owner_req || (accept && at_limit && !lock_eff)) begin
                    gnt_d   = '0;
                    ptr_d   = owner + 2'd1;
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                end else if (accept) begin
                    // Saturate so a long locked burst cannot wrap the count
                    cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_inc[3:0];
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State registers, asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= 4'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == StGrant);

    lab4_g29_mux_arb_mux4 u_mux (
        .a_i   (a),
        .b_i   (b),
        .c_i   (c),
        .d_i   (d),
        .sel_i (sel_q),
        .y_o   (y)
    );

endmodule

// File: tb/tb_lab4_g29_mux_arb.sv
// Directed self-checking bench for lab4_g29_mux_arb (MAX_BURST = 4).
// Vectors use index order: bit k of req/gnt is requester k (leftmost = 0).
module tb_lab4_g29_mux_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:3] a, b, c, d;
    logic [0:3] req;
    logic [0:3] gnt;
    logic [0:1] sel;
    logic [0:3] y;
    logic       y_valid;
    logic       y_ready;
    logic       busy;
`ifdef LAB4_G29_LOCK_EN
    logic       lock;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [0:3] DA = 4'h3;
    localparam logic [0:3] DB = 4'h5;
    localparam logic [0:3] DC = 4'hA;
    localparam logic [0:3] DD = 4'hC;

    logic rdy_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    lab4_g29_mux_arb #(.MAX_BURST(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .req     (req),
`ifdef LAB4_G29_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy)
    );

    function automatic logic [0:3] oh(input int k);
        logic [0:3] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:3] dat(input int k);
        case (k)
            0:       return DA;
            1:       return DB;
            2:       return DC;
            default: return DD;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Owner k granted: one-hot gnt, select decodes to k, y shows k's word
    task automatic chk_grant(input string tag, input int k);
        chk({tag, " gnt"}, 32'(gnt), 32'(oh(k)));
        chk({tag, " sel"}, 32'({sel[1], sel[0]}), 32'(k));
        chk({tag, " y"}, 32'(y), 32'(dat(k)));
        chk({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " gnt"}, 32'(gnt), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " y_valid"}, 32'(y_valid), 32'd0);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        a = DA; b = DB; c = DC; d = DD;
        rst_n   = 1'b0;
        req     = 4'b1111;
        y_ready = 1'b0;
`ifdef LAB4_G29_LOCK_EN
        lock = 1'b0;
`endif
        // Reset held with all requests raised
        tick();
        tick();
        chk_idle("reset");
        chk("reset sel", 32'(sel), 32'd0);
        chk("reset y", 32'(y), 32'(DA));
        req   = '0;
        rst_n = 1'b1;
        tick();
        chk_idle("post reset");

        // Single requester 2: 4 beats, bubble, re-grant
        req     = oh(2);
        y_ready = 1'b1;
        #1;
        chk_idle("t1 pre");
        tick();
        for (int j = 0; j < 4; j++) begin
            chk_grant("t1 beat", 2);
            chk("t1 y_valid", 32'(y_valid), 32'd1);
            tick();
        end
        chk_idle("t1 bubble");
        chk("t1 bubble y", 32'(y), 32'(DC));
        tick();
        chk_grant("t1 regrant", 2);
        req = '0;
        #1;
        chk("t1 drop y_valid", 32'(y_valid), 32'd0);
        tick();
        chk_idle("t1 drop release");

        // Round robin, all requesting: order 0,1,2,3,0, 4 beats each
        rst_pulse();
        req = 4'b1111;
        tick();
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 4; j++) begin
                chk_grant("t2 beat", r % 4);
                tick();
            end
            chk_idle("t2 bubble");
            tick();
        end
        chk_grant("t2 next", 1);
        req = '0;
        tick();
        chk_idle("t2 end");

        // Backpressure on owner 1: ready 1,0,0,1,1,1
        rst_pulse();
        req     = oh(1);
        y_ready = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            y_ready = rdy_seq[i];
            #1;
            chk_grant("t3 stall", 1);
            chk("t3 y_valid", 32'(y_valid), 32'd1);
            tick();
        end
        chk_idle("t3 release");
        req     = '0;
        y_ready = 1'b1;

        // Early drop by owner 3 after 2 accepts, 0 and 1 pending
        req = oh(3);
        tick();
        chk_grant("t4 grant", 3);
        tick();
        chk_grant("t4 beat2", 3);
        tick();
        req = 4'b1100;
        #1;
        chk("t4 drop y_valid", 32'(y_valid), 32'd0);
        chk_grant("t4 drop", 3);
        tick();
        chk_idle("t4 release");
        tick();
        chk_grant("t4 next", 0);
        req = '0;
        tick();
        chk_idle("t4 end");

        // Async reset mid-burst (pointer is 1 here)
        req = oh(1);
        tick();
        chk_grant("t5 grant", 1);
        tick();
        tick();
        chk_grant("t5 beat2", 1);
        rst_n = 1'b0;
        #1;
        chk_idle("t5 async");
        chk("t5 async sel", 32'(sel), 32'd0);
        chk("t5 async y", 32'(y), 32'(DA));
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        chk_grant("t5 after rst", 0);
        req = '0;
        tick();
        chk_idle("t5 end");

`ifdef LAB4_G29_LOCK_EN
        // Locked burst runs past MAX_BURST
        rst_pulse();
        lock = 1'b1;
        req  = oh(2);
        tick();
        for (int j = 0; j < 7; j++) begin
            chk_grant("t6 locked", 2);
            tick();
        end
        chk_grant("t6 held", 2);
        req  = '0;
        lock = 1'b0;
        tick();
        chk_idle("t6 release");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
